vec_mac_sequencer: RTL and testbench

//  Top-level sequencer for the vector-multiplier datapath. On one start it computes NUM_ROWS dot products of VEC_LEN elements each.
//  For every row it clears the accumulator, streams operand read addresses and aligns a MAC enable to the operand-memory read latency.
//  It then waits for the MAC pipeline to drain and writes the row result. It sits between the host start/done handshake and the operand RAMs, MAC unit and result RAM.

---
 rtl/vec_mac_sequencer.sv | 124 ++++++++++++
 tb/tb_vec_mac_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mac_sequencer.sv
// Row-by-row dot-product sequencer: clears the accumulator, streams operand addresses,
// aligns the MAC enable to RAM read latency, drains the MAC pipe and writes each row result.
module vec_mac_sequencer #(
  parameter int VEC_LEN  = 24,
  parameter int NUM_ROWS = 4,
  parameter int RD_LAT   = 1,
  parameter int MAC_LAT  = 2,
  localparam int ADDR_W  = $clog2(VEC_LEN),
  localparam int ROW_W   = $clog2(NUM_ROWS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ROW_W-1:0]  row_idx,
  output logic              acc_clr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              mac_en,
  output logic              mac_last,
  output logic              res_we,
  output logic [ROW_W-1:0]  res_addr
);

  localparam int DRAIN = RD_LAT + MAC_LAT;
  localparam int CNT_W = $clog2(DRAIN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_WRITE, S_FINISH
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  drain_cnt;
  logic [RD_LAT-1:0] vld_pipe;
  logic [RD_LAT-1:0] last_pipe;
  logic              addr_last, row_last;
  logic              busy_d, done_d, acc_clr_d, rd_en_d, res_we_d;

  assign addr_last = (rd_addr == ADDR_W'(VEC_LEN - 1));
  assign row_last  = (row_idx == ROW_W'(NUM_ROWS - 1));

  // State register plus the registered Moore outputs decoded from the next state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      acc_clr <= 1'b0;
      rd_en   <= 1'b0;
      res_we  <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy    <= busy_d;
      done    <= done_d;
      acc_clr <= acc_clr_d;
      rd_en   <= rd_en_d;
      res_we  <= res_we_d;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) state_nxt = S_CLEAR;
        S_CLEAR:  state_nxt = S_ISSUE;
        S_ISSUE:  if (addr_last) state_nxt = S_DRAIN;
        S_DRAIN:  if (drain_cnt == '0) state_nxt = S_WRITE;
        S_WRITE:  state_nxt = row_last ? S_FINISH : S_CLEAR;
        S_FINISH: state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_d    = (state_nxt != S_IDLE);
    acc_clr_d = (state_nxt == S_CLEAR);
    rd_en_d   = (state_nxt == S_ISSUE);
    res_we_d  = (state_nxt == S_WRITE);
    done_d    = (state_nxt == S_FINISH);
  end

  // Counters and the read-latency delay line; abort flushes everything so no stale
  // mac_en or partial row survives into the next job.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_addr   <= '0;
      row_idx   <= '0;
      drain_cnt <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else if (abort) begin
      rd_addr   <= '0;
      row_idx   <= '0;
      drain_cnt <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      case (state)
        S_IDLE:  if (start) row_idx <= '0;
        S_CLEAR: rd_addr <= '0;
        S_ISSUE: begin
          rd_addr <= addr_last ? '0 : rd_addr + ADDR_W'(1);
          if (addr_last) drain_cnt <= CNT_W'(DRAIN - 1);
        end
        S_DRAIN: if (drain_cnt != '0) drain_cnt <= drain_cnt - CNT_W'(1);
        S_WRITE: if (!row_last) row_idx <= row_idx + ROW_W'(1);
        default: ;
      endcase
      vld_pipe  <= (vld_pipe << 1)  | RD_LAT'(rd_en);
      last_pipe <= (last_pipe << 1) | RD_LAT'(rd_en && addr_last);
    end
  end

  assign mac_en   = vld_pipe[RD_LAT-1];
  assign mac_last = last_pipe[RD_LAT-1];
  assign res_addr = row_idx;

endmodule

// File: tb/tb_vec_mac_sequencer.sv
// Bench for vec_mac_sequencer: a job-timeline model checked every cycle on two
// configurations, plus directed scenarios with hand-computed cycle expectations.
module tb_vec_mac_sequencer;

  logic clk, rstn;
  logic start_a, abort_a, start_b, abort_b;

  logic       busy_a, done_a, acc_clr_a, rd_en_a, mac_en_a, mac_last_a, res_we_a;
  logic [1:0] row_idx_a, res_addr_a;
  logic [4:0] rd_addr_a;

  logic       busy_b, done_b, acc_clr_b, rd_en_b, mac_en_b, mac_last_b, res_we_b;
  logic [1:0] row_idx_b, res_addr_b;
  logic [2:0] rd_addr_b;

  int passed = 0, total = 0;
  int cur;

  vec_mac_sequencer dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .row_idx(row_idx_a), .acc_clr(acc_clr_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .mac_en(mac_en_a), .mac_last(mac_last_a),
    .res_we(res_we_a), .res_addr(res_addr_a)
  );

  vec_mac_sequencer #(.VEC_LEN(5), .NUM_ROWS(3), .RD_LAT(2), .MAC_LAT(0)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .row_idx(row_idx_b), .acc_clr(acc_clr_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .mac_en(mac_en_b), .mac_last(mac_last_b),
    .res_we(res_we_b), .res_addr(res_addr_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic busy, done, acc_clr, rd_en, mac_en, mac_last, res_we;
    int   rd_addr;
    int   row;
  } exp_t;

  // Expected outputs from t = cycles since the accepting edge (0 = idle).
  function automatic exp_t model(input int t, input int held, input int V, input int R,
                                 input int RL, input int ML);
    exp_t e;
    int p, r, o;
    e = '0;
    p = V + RL + ML + 2;
    if (t == 0) begin
      e.row = held;
      return e;
    end
    e.busy = 1'b1;
    if (t == R * p + 1) begin
      e.done = 1'b1;
      e.row  = R - 1;
      return e;
    end
    r = (t - 1) / p;
    o = (t - 1) % p;
    e.row      = r;
    e.acc_clr  = (o == 0);
    e.rd_en    = (o >= 1) && (o <= V);
    e.rd_addr  = e.rd_en ? o - 1 : 0;
    e.mac_en   = (o - RL >= 1) && (o - RL <= V);
    e.mac_last = (o == V + RL);
    e.res_we   = (o == p - 1);
    return e;
  endfunction

  int t_a, held_a, t_b, held_b;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t_a <= 0; held_a <= 0;
    end else if (abort_a) begin
      t_a <= 0; held_a <= 0;
    end else if (t_a == 0) begin
      if (start_a) t_a <= 1;
    end else if (t_a == 4 * 29 + 1) begin
      t_a <= 0; held_a <= 3;
    end else begin
      t_a <= t_a + 1;
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t_b <= 0; held_b <= 0;
    end else if (abort_b) begin
      t_b <= 0; held_b <= 0;
    end else if (t_b == 0) begin
      if (start_b) t_b <= 1;
    end else if (t_b == 3 * 9 + 1) begin
      t_b <= 0; held_b <= 2;
    end else begin
      t_b <= t_b + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else passed++;
  endtask

  task automatic cmp(input string p, input exp_t e, input logic bz, input logic dn,
                     input logic clr, input logic re, input logic me, input logic ml,
                     input logic we, input logic [31:0] addr, input logic [31:0] row,
                     input logic [31:0] raddr);
    chk({p, "_busy"}, 32'(bz), 32'(e.busy));
    chk({p, "_done"}, 32'(dn), 32'(e.done));
    chk({p, "_acc_clr"}, 32'(clr), 32'(e.acc_clr));
    chk({p, "_rd_en"}, 32'(re), 32'(e.rd_en));
    chk({p, "_mac_en"}, 32'(me), 32'(e.mac_en));
    chk({p, "_mac_last"}, 32'(ml), 32'(e.mac_last));
    chk({p, "_res_we"}, 32'(we), 32'(e.res_we));
    chk({p, "_rd_addr"}, addr, e.rd_addr);
    chk({p, "_row_idx"}, row, e.row);
    if (e.res_we) chk({p, "_res_addr"}, raddr, e.row);
  endtask

  always @(negedge clk) begin
    cmp("a", model(t_a, held_a, 24, 4, 1, 2), busy_a, done_a, acc_clr_a, rd_en_a,
        mac_en_a, mac_last_a, res_we_a, 32'(rd_addr_a), 32'(row_idx_a), 32'(res_addr_a));
    cmp("b", model(t_b, held_b, 5, 3, 2, 0), busy_b, done_b, acc_clr_b, rd_en_b,
        mac_en_b, mac_last_b, res_we_b, 32'(rd_addr_b), 32'(row_idx_b), 32'(res_addr_b));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic to_cycle(input int c);
    while (cur < c) begin
      step();
      cur++;
    end
  endtask

  task automatic go_a();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    cur = 1;
  endtask

  initial begin
    int n_done, n_clr, n_we;
    rstn = 1'b0; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    #3;
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_rd_en", 32'(rd_en_a), 0);
    chk("rst_mac_en", 32'(mac_en_a), 0);
    chk("rst_b_busy", 32'(busy_b), 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    step();

    // T1: single job with default sizes
    go_a();
    n_done = 0;
    for (int c = 1; c <= 118; c++) begin
      to_cycle(c);
      @(negedge clk);
      n_done += 32'(done_a);
      case (c)
        1:   begin chk("t1_clr_c1", 32'(acc_clr_a), 1); chk("t1_rden_c1", 32'(rd_en_a), 0); end
        2:   begin chk("t1_rden_c2", 32'(rd_en_a), 1); chk("t1_addr_c2", 32'(rd_addr_a), 0);
                   chk("t1_macen_c2", 32'(mac_en_a), 0); end
        3:   chk("t1_macen_c3", 32'(mac_en_a), 1);
        25:  chk("t1_addr_c25", 32'(rd_addr_a), 23);
        26:  begin chk("t1_last_c26", 32'(mac_last_a), 1); chk("t1_rden_c26", 32'(rd_en_a), 0); end
        27:  chk("t1_macen_c27", 32'(mac_en_a), 0);
        29:  begin chk("t1_we_c29", 32'(res_we_a), 1); chk("t1_waddr_c29", 32'(res_addr_a), 0); end
        30:  begin chk("t1_clr_c30", 32'(acc_clr_a), 1); chk("t1_row_c30", 32'(row_idx_a), 1); end
        88:  begin chk("t1_clr_c88", 32'(acc_clr_a), 1); chk("t1_row_c88", 32'(row_idx_a), 3); end
        116: begin chk("t1_we_c116", 32'(res_we_a), 1); chk("t1_waddr_c116", 32'(res_addr_a), 3); end
        117: chk("t1_done_c117", 32'(done_a), 1);
        118: begin chk("t1_busy_c118", 32'(busy_a), 0); chk("t1_row_hold", 32'(row_idx_a), 3); end
        default: ;
      endcase
    end
    chk("t1_done_count", n_done, 1);

    // T2: start held high across two jobs
    start_a = 1'b1;
    step();
    cur = 1;
    n_done = 0; n_clr = 0;
    for (int c = 1; c <= 236; c++) begin
      to_cycle(c);
      if (c == 236) start_a = 1'b0;
      @(negedge clk);
      n_done += 32'(done_a);
      n_clr  += 32'(acc_clr_a);
      case (c)
        117: chk("t2_done_c117", 32'(done_a), 1);
        118: chk("t2_idle_gap", 32'(busy_a), 0);
        119: chk("t2_clr_c119", 32'(acc_clr_a), 1);
        235: chk("t2_done_c235", 32'(done_a), 1);
        236: chk("t2_idle_end", 32'(busy_a), 0);
        default: ;
      endcase
    end
    chk("t2_done_count", n_done, 2);
    chk("t2_clr_count", n_clr, 8);

    // T3: abort mid-issue of row 2, then a clean job
    step();
    go_a();
    to_cycle(70);
    chk("t3_addr_pre", 32'(rd_addr_a), 10);
    chk("t3_row_pre", 32'(row_idx_a), 2);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    @(negedge clk);
    chk("t3_busy_post", 32'(busy_a), 0);
    chk("t3_rden_post", 32'(rd_en_a), 0);
    chk("t3_macen_post", 32'(mac_en_a), 0);
    chk("t3_row_post", 32'(row_idx_a), 0);
    n_done = 0; n_we = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n_done += 32'(done_a);
      n_we   += 32'(res_we_a);
    end
    chk("t3_no_done", n_done, 0);
    chk("t3_no_we", n_we, 0);
    step();
    go_a();
    n_done = 0; n_we = 0;
    for (int c = 1; c <= 118; c++) begin
      to_cycle(c);
      @(negedge clk);
      n_done += 32'(done_a);
      n_we   += 32'(res_we_a);
      if (c == 117) chk("t3_done_c117", 32'(done_a), 1);
    end
    chk("t3_job_done_count", n_done, 1);
    chk("t3_job_we_count", n_we, 4);

    // T4: start and abort together in idle
    step();
    start_a = 1'b1; abort_a = 1'b1;
    step();
    start_a = 1'b0; abort_a = 1'b0;
    @(negedge clk);
    chk("t4_busy_both", 32'(busy_a), 0);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    @(negedge clk);
    chk("t4_busy_start", 32'(busy_a), 1);
    chk("t4_clr_start", 32'(acc_clr_a), 1);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;

    // T5: asynchronous reset during drain of row 1
    step();
    go_a();
    to_cycle(55);
    @(negedge clk);
    chk("t5_row_drain", 32'(row_idx_a), 1);
    chk("t5_rden_drain", 32'(rd_en_a), 0);
    chk("t5_macen_drain", 32'(mac_en_a), 1);
    #2 rstn = 1'b0;
    #1;
    chk("t5_busy_rst", 32'(busy_a), 0);
    chk("t5_macen_rst", 32'(mac_en_a), 0);
    chk("t5_row_rst", 32'(row_idx_a), 0);
    chk("t5_addr_rst", 32'(rd_addr_a), 0);
    #1 rstn = 1'b1;
    n_done = 0; n_we = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      n_done += 32'(done_a) + 32'(busy_a);
      n_we   += 32'(res_we_a);
    end
    chk("t5_quiet_done_busy", n_done, 0);
    chk("t5_quiet_we", n_we, 0);

    // T6: small non-power-of-2 config with RD_LAT=2
    step();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    cur = 1;
    n_done = 0;
    for (int c = 1; c <= 29; c++) begin
      to_cycle(c);
      @(negedge clk);
      n_done += 32'(done_b);
      chk("t6_addr_range", 32'(rd_addr_b < 3'd5), 1);
      case (c)
        2:  begin chk("t6_rden_c2", 32'(rd_en_b), 1); chk("t6_macen_c2", 32'(mac_en_b), 0); end
        3:  chk("t6_macen_c3", 32'(mac_en_b), 0);
        4:  chk("t6_macen_c4", 32'(mac_en_b), 1);
        6:  chk("t6_addr_c6", 32'(rd_addr_b), 4);
        7:  chk("t6_rden_c7", 32'(rd_en_b), 0);
        8:  begin chk("t6_last_c8", 32'(mac_last_b), 1); chk("t6_macen_c8", 32'(mac_en_b), 1); end
        9:  begin chk("t6_we_c9", 32'(res_we_b), 1); chk("t6_macen_c9", 32'(mac_en_b), 0); end
        10: begin chk("t6_clr_c10", 32'(acc_clr_b), 1); chk("t6_row_c10", 32'(row_idx_b), 1); end
        27: begin chk("t6_we_c27", 32'(res_we_b), 1); chk("t6_waddr_c27", 32'(res_addr_b), 2); end
        28: chk("t6_done_c28", 32'(done_b), 1);
        29: chk("t6_busy_c29", 32'(busy_b), 0);
        default: ;
      endcase
    end
    chk("t6_done_count", n_done, 1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
